// File: rtl/div_seq.sv
// Iterative 32-bit integer divider for the EX stage: restoring division, one
// quotient bit per cycle, with the divide-by-zero and signed-overflow cases short-circuited.
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hold,
  input  logic            flush,
  output logic            stallreq,
  output logic [XLEN-1:0] result,
  output logic            done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [5:0]      cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic            neg_q, neg_r, is_rem;

  logic            a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic [XLEN:0]   rem_sh, rem_nx;
  logic [XLEN-1:0] quo_nx, q_fix, r_fix;
  logic            ge;

  // op[0]=1 selects the unsigned forms, op[1]=1 selects the remainder
  assign a_neg    = ~op[0] & a[XLEN-1];
  assign b_neg    = ~op[0] & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = (b == '0);
  assign ovf      = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
  assign special  = div_zero | ovf;

  always_comb begin
    spec_res = '0;
    if (div_zero)  spec_res = op[1] ? a : '1;
    else if (ovf)  spec_res = op[1] ? '0 : a;
  end

  // The remainder never exceeds the divisor, so only the shifted value needs the extra bit
  assign rem_sh = {rem, quo[XLEN-1]};
  assign ge     = (rem_sh >= {1'b0, dvs});
  assign rem_nx = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
  assign quo_nx = {quo[XLEN-2:0], ge};
  assign q_fix  = neg_q ? -quo_nx : quo_nx;
  assign r_fix  = neg_r ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (special) begin
            result <= spec_res;
            state  <= DONE;
          end else begin
            quo    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            cnt    <= '0;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            is_rem <= op[1];
            state  <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nx[XLEN-1:0];
          quo <= quo_nx;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            result <= is_rem ? r_fix : q_fix;
            state  <= DONE;
          end
        end
        DONE: if (!hold) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stallreq = start & ~flush & (state != DONE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed corner cases, hold/flush/reset
// sequences and a few random operands checked against a behavioural model.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        rst_n, start, hold, flush;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  logic        stallreq, done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  div_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hold(hold), .flush(flush), .stallreq(stallreq), .result(result), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : x;
    case (o)
      2'd0:    return sx / sy;
      2'd1:    return x / y;
      2'd2:    return sx % sy;
      default: return x % y;
    endcase
  endfunction

  // Issue one op, wait for done, check latency/stall/result, optionally hold done for nhold extra cycles
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat, input int nhold);
    int          cyc, stall_cnt;
    bit          seen;
    logic [31:0] r0;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; hold = (nhold > 0);
    sb.push_back(exp);
    cyc = 0; stall_cnt = 0; seen = 1'b0;
    while (!seen && cyc <= 60) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (stallreq) stall_cnt++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    r0 = sb.pop_front();
    if (seen) begin
      chk("latency", 32'(cyc), 32'(lat));
      chk("stall_cycles", 32'(stall_cnt), 32'(lat));
      chk("stall_in_done", 32'(stallreq), 32'd0);
      chk("result", result, r0);
      for (int i = 0; i < nhold; i++) begin
        @(posedge clk); #1;
        if (i == nhold - 1) hold = 1'b0;
        @(negedge clk);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_result", result, r0);
        chk("hold_stall", 32'(stallreq), 32'd0);
      end
    end
    @(posedge clk); #1;
    start = 1'b0; hold = 1'b0;
    @(negedge clk);
    chk("idle_after", 32'(done), 32'd0);
  endtask

  initial begin
    bit          any_done;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    rst_n = 1'b0; start = 1'b1; hold = 1'b0; flush = 1'b0; op = 2'd1; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_stall", 32'(stallreq), 32'd1);
    flush = 1'b1; #1;
    chk("rst_stall_flush", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0; rst_n = 1'b1;

    do_op(2'd1, 32'd100, 32'd7, 32'd14, 33, 0);
    do_op(2'd3, 32'd100, 32'd7, 32'd2, 33, 0);
    do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    do_op(2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    do_op(2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op(2'd3, 32'd5, 32'd0, 32'd5, 1, 0);
    do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    do_op(2'd1, 32'd100, 32'd7, 32'd14, 33, 4);

    // flush in the middle of an iteration
    @(posedge clk); #1;
    start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd7;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 36; i++) begin @(negedge clk); if (done) any_done = 1'b1; end
    chk("flush_no_done", 32'(any_done), 32'd0);
    do_op(2'd1, 32'd9, 32'd3, 32'd3, 33, 0);

    // synchronous reset in the middle of an iteration
    @(posedge clk); #1;
    start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd7;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_result", result, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_stall", 32'(stallreq), 32'd0);
    do_op(2'd3, 32'hFFFF_FFFF, 32'd16, 32'd15, 33, 0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      case (i % 4)
        0:       ry = $urandom;
        1:       ry = $urandom_range(1, 255);
        2:       ry = -$urandom_range(1, 9);
        default: ry = 32'd0;
      endcase
      do_op(ro, rx, ry, model(ro, rx, ry),
            (ry == 32'd0 || (!ro[0] && rx == 32'h8000_0000 && ry == 32'hFFFF_FFFF)) ? 1 : 33, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
